// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the instruction decoder.
//
// Owns the PC and issues one word read at a time to instruction memory over a
// req/ack handshake. Fetched words are buffered in a small FIFO and presented
// to decode with valid/ready, each tagged with its PC. A redirect flushes the
// buffer and restarts fetch at the target. A misaligned target halts fetch
// until reset and raises the sticky fetch_exception flag.
//
// Parameters:
//   RESET_PC    PC loaded on reset (word-aligned)
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, reset                          clock, async active-high reset
//   imem_req/imem_addr                  read request, held until imem_ack
//   imem_ack/imem_data                  read completion and fetched word
//   instr_valid/instr/instr_pc          buffer head presented to decode
//   instr_ready                         decode accepts head
//   redirect_valid/redirect_pc          flow-control redirect pulse
//   fetch_exception                     sticky misaligned-target flag
//   fetch_count (FETCH_COUNT_EN only)   instructions handed to decode
//
// Build option: define FETCH_COUNT_EN to add the fetch_count port/counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding; issue when a buffer slot is free
// REQ      | request to imem_addr outstanding; ack data is buffered
// DRAIN    | request outstanding but redirected; ack data is dropped
// HALT     | misaligned redirect seen; no fetch until reset

module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_COUNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic        fetch_exception
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             misaligned;
    logic             flush;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] occ_after_pop;
    logic             can_issue;
    logic             slot_after_push;

    assign instr_valid = (count != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    // Request stays up through DRAIN so the abandoned read still completes.
    assign imem_req    = (state == ST_REQ) || (state == ST_DRAIN);

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign flush           = redirect_valid && (state != ST_HALT);
    // A redirect flushes the buffer, so a same-cycle handshake is not a pop.
    assign pop             = instr_valid && instr_ready && !redirect_valid;
    assign push            = (state == ST_REQ) && imem_ack && !redirect_valid;
    // Slot accounting sees this cycle's pop, so a full buffer being drained
    // can still issue the next read in the same cycle.
    assign occ_after_pop   = count - CNT_W'(pop);
    assign can_issue       = occ_after_pop < DEPTH_C;
    assign slot_after_push = (occ_after_pop + CNT_W'(1)) < DEPTH_C;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_data;
                fifo_pc[wr_ptr]    <= pc;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= occ_after_pop + CNT_W'(push);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            pc              <= RESET_PC;
            imem_addr       <= RESET_PC;
            fetch_exception <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (misaligned) begin
                            fetch_exception <= 1'b1;
                            state           <= ST_HALT;
                        end
                    end else if (can_issue) begin
                        state     <= ST_REQ;
                        imem_addr <= pc;
                    end
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (misaligned) begin
                            fetch_exception <= 1'b1;
                        end
                        if (imem_ack) begin
                            state <= misaligned ? ST_HALT : ST_IDLE;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (slot_after_push) begin
                            imem_addr <= pc + 32'd4;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Later redirects only retarget; the last one wins.
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (misaligned) begin
                            fetch_exception <= 1'b1;
                        end
                    end
                    if (imem_ack) begin
                        state <= (fetch_exception || (redirect_valid && misaligned))
                                 ? ST_HALT : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    // Delivery counter not built in this configuration.
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly upstream of the instruction decoder. Owns the PC and issues word reads to instruction memory over a req/ack handshake; only one read is outstanding at a time. Fetched words go into a small FIFO and are presented to decode with valid/ready, each tagged with its PC. Flow-control redirects flush the FIFO and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  read request; once raised, held high with stable imem_addr until imem_ack.
imem_addr  out  32  word-aligned fetch address.
imem_ack  in  1  read complete; imem_data valid this cycle; only meaningful while imem_req=1.
imem_data  in  32  fetched instruction word.
instr_valid  out  1  FIFO head valid.
instr  out  32  FIFO head instruction word.
instr_pc  out  32  PC of FIFO head.
instr_ready  in  1  decode consumes head when instr_valid & instr_ready.
redirect_valid  in  1  flow-control redirect; single-cycle pulse.
redirect_pc  in  32  redirect target.
fetch_exception  out  1  sticky flag: misaligned redirect target; fetch halted.

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_exception=0.
- States: IDLE, REQ, DRAIN, HALT.
- IDLE: if free slots > 0 (FIFO_DEPTH minus occupancy, counted after this cycle's pop), next cycle enters REQ with imem_req=1 and imem_addr=pc.
- REQ: on imem_ack, push {pc, imem_data} and set pc=pc+4 (wraps mod 2^32). Same cycle: if a free slot remains after the push, stay in REQ and issue the next address back-to-back; otherwise go to IDLE.
- Zero-wait memory (ack in the first cycle of req) must sustain 1 instruction/cycle while decode accepts every cycle.
- Redirect in IDLE: flush FIFO, pc=redirect_pc, stay IDLE. instr_valid=0 next cycle.
- Redirect in REQ without ack that cycle: flush, pc=redirect_pc, go to DRAIN. imem_req stays high at the old address until ack.
- Redirect in REQ with ack the same cycle: discard the acked data (no push), flush, pc=redirect_pc, go to IDLE.
- DRAIN: on imem_ack, discard data and go to IDLE. A further redirect in DRAIN only updates pc (last one wins).
- Redirect with redirect_pc[1:0]!=0: flush, go to HALT (after DRAIN if a request is outstanding), fetch_exception=1. HALT issues no requests, keeps instr_valid=0, and is left only by reset.
- FIFO push and pop in the same cycle keep occupancy unchanged. A pop on a full FIFO frees a slot usable for a request that same cycle.
- Redirect and pop in the same cycle: flush wins; the pop is ignored.
- instr/instr_pc remain stable while instr_valid=1 and instr_ready=0.
- Reset asserted mid-request: imem_req drops immediately (async); the memory model must tolerate an abandoned request.

Optional Feature:
FETCH_COUNT_EN. When defined: extra port fetch_count (out, 32) counts instructions delivered to decode (valid&ready handshakes). It resets to 0, wraps mod 2^32, and does not count flushed entries. When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
1. Reset with RESET_PC=0x100, zero-wait memory returning addr^0xA5A5_0000, instr_ready=1 -> instr_pc 0x100, 0x104, 0x108 on consecutive cycles after the first fill, with matching data.
2. Hold instr_ready=0 -> exactly FIFO_DEPTH (2) reads issued, then imem_req=0; raise instr_ready -> entries drain in order (0x100, 0x104) and fetch resumes at 0x108.
3. Memory with 3-cycle ack; redirect_pc=0x200 pulsed 1 cycle after req rises -> ack for the old address discarded, next request at 0x200, first delivered instr_pc=0x200.
4. Redirect to 0x300 in the same cycle as imem_ack with FIFO holding 1 entry -> FIFO empty next cycle, no entry from the old stream ever delivered, next request 0x300.
5. Redirect to 0x402 -> fetch_exception=1 (sticky), imem_req stays 0 and instr_valid stays 0 for 20 cycles; assert reset -> exception clears and fetch restarts at RESET_PC.
6. FETCH_COUNT_EN defined: deliver 5 instructions, flush 2 buffered entries via redirect -> fetch_count=5; with pc started at 0xFFFF_FFFC -> next instr_pc wraps to 0x0000_0000.
